// File: rtl/sin_pkg.sv
// Shared constants, quadrant type and the quarter-wave sine table for sin_block.
// The table is built at elaboration with an integer Taylor series, so no real arithmetic reaches hardware.
package sin_pkg;

  localparam int PHASE_W   = 16;
  localparam int OUT_W     = 16;
  localparam int SEG_BITS  = 7;
  localparam int FRAC_BITS = 7;
  localparam int LATENCY   = 2;

  localparam int K_W   = SEG_BITS + 1;
  localparam int TBL_N = (1 << SEG_BITS) + 1;
  localparam int TBL_W = SEG_BITS + FRAC_BITS + 1;

  localparam logic [OUT_W-1:0] ONE = 16'h4000;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  // round(16384*sin(k*pi/256)) for k = 0..128, packed 15 bits per entry, entry k at bit k*15
  function automatic logic [TBL_N*TBL_W-1:0] build_table();
    logic [TBL_N*TBL_W-1:0] t;
    longint pi_q30;
    longint theta;
    longint term;
    longint acc;
    pi_q30 = 64'sd3373259426;
    t = '0;
    for (int k = 0; k < TBL_N; k++) begin
      theta = (pi_q30 * longint'(k)) >>> 8;
      term  = theta;
      acc   = theta;
      for (int n = 1; n <= 8; n++) begin
        term = (term * theta) >>> 30;
        term = (term * theta) >>> 30;
        term = -term / longint'((2 * n) * (2 * n + 1));
        acc  = acc + term;
      end
      t[k*TBL_W +: TBL_W] = TBL_W'((acc * 64'sd16384 + (64'sd1 <<< 29)) >>> 30);
    end
    return t;
  endfunction

  localparam logic [TBL_N*TBL_W-1:0] SIN_TBL = build_table();

endpackage

// File: rtl/sin_quarter_rom.sv
// Combinational dual-read of the 129-entry quarter-wave table: T[k] and T[k+1].
module sin_quarter_rom
  import sin_pkg::*;
(
  input  logic [K_W-1:0]   k_i,
  output logic [TBL_W-1:0] t0_o,
  output logic [TBL_W-1:0] t1_o
);

  localparam logic [K_W-1:0] SEG_LAST = K_W'(TBL_N - 1);

  logic [K_W-1:0] k_next;

  // At the last index the fraction is always zero, so clamp rather than read past the table.
  assign k_next = (k_i >= SEG_LAST) ? SEG_LAST : k_i + K_W'(1);

  assign t0_o = SIN_TBL[int'(k_i) * TBL_W +: TBL_W];
  assign t1_o = SIN_TBL[int'(k_next) * TBL_W +: TBL_W];

endmodule

// File: rtl/sin_block.sv
// Pipelined Q2.14 sine/cosine generator: stage 1 folds the phase into index/fraction/sign,
// stage 2 interpolates between adjacent table entries and applies the sign.
module sin_block
  import sin_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               func,
  input  logic [PHASE_W-1:0] x,
  output logic [OUT_W-1:0]   sineValue
);

  localparam logic [PHASE_W-1:0] QUARTER_TURN = PHASE_W'(ONE);
  localparam logic [TBL_W-1:0]   QUARTER_OFF  = TBL_W'(ONE);
  localparam int                 PROD_W       = TBL_W + FRAC_BITS;
  localparam logic [PROD_W-1:0]  HALF_LSB     = PROD_W'(1 << (FRAC_BITS - 1));

  logic [PHASE_W-1:0]   phase;
  quad_e                quad;
  logic [PHASE_W-3:0]   off;
  logic [TBL_W-1:0]     fold;
  logic                 neg_d, neg_q;
  logic [K_W-1:0]       k_d, k_q;
  logic [FRAC_BITS-1:0] f_d, f_q;
  logic [TBL_W-1:0]     t0, t1, step, mag;
  logic [PROD_W-1:0]    prod;
  logic [OUT_W-1:0]     sine_d, sine_q;

  assign phase = func ? x + QUARTER_TURN : x;
  assign quad  = quad_e'(phase[PHASE_W-1 -: 2]);
  assign off   = phase[PHASE_W-3:0];

  // Odd quadrants run the table backwards; mirrored offset may reach 16384 (index 128, frac 0).
  always_comb begin
    fold  = {1'b0, off};
    neg_d = 1'b0;
    unique case (quad)
      Q0: fold = {1'b0, off};
      Q1: fold = QUARTER_OFF - {1'b0, off};
      Q2: neg_d = 1'b1;
      Q3: begin
        fold  = QUARTER_OFF - {1'b0, off};
        neg_d = 1'b1;
      end
    endcase
  end

  assign k_d = fold[TBL_W-1 -: K_W];
  assign f_d = fold[FRAC_BITS-1:0];

  sin_quarter_rom u_rom (
    .k_i  (k_q),
    .t0_o (t0),
    .t1_o (t1)
  );

  // Table is monotonic over the quarter wave, so the slope is never negative.
  assign prod   = PROD_W'(t1 - t0) * PROD_W'(f_q) + HALF_LSB;
  assign step   = TBL_W'(prod >> FRAC_BITS);
  assign mag    = t0 + step;
  assign sine_d = neg_q ? OUT_W'(0) - OUT_W'(mag) : OUT_W'(mag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_q  <= 1'b0;
      k_q    <= '0;
      f_q    <= '0;
      sine_q <= '0;
    end else begin
      neg_q  <= neg_d;
      k_q    <= k_d;
      f_q    <= f_d;
      sine_q <= sine_d;
    end
  end

  assign sineValue = sine_q;

endmodule

// File: tb/tb_sin_block.sv
// Scoreboard bench for sin_block: stimulus queues expected samples, a negedge monitor checks them.
module tb_sin_block;
  import sin_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        func  = 1'b0;
  logic [15:0] x     = 16'h0000;
  logic [15:0] sineValue;

  sin_block dut (
    .clk       (clk),
    .reset     (reset),
    .func      (func),
    .x         (x),
    .sineValue (sineValue)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        f;
    logic [15:0] xv;
    int          exp;
    int          tol;
    bit          ideal;
    bit          sym;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] got_sin[int];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req, int tol);
    int d;
    n_checks++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
    end
  endfunction

  function automatic int tval(int k);
    return int'($floor(16384.0 * $sin(real'(k) * PI / 256.0) + 0.5));
  endfunction

  // Reference: quadrant rules plus linear interpolation between rounded table points.
  function automatic int model(logic f, logic [15:0] xv);
    int p, q, o, a, k, fr, s;
    p = (int'(xv) + (f ? 16384 : 0)) % 65536;
    q = p / 16384;
    o = p % 16384;
    a = (q % 2 == 1) ? 16384 - o : o;
    k = a / 128;
    fr = a % 128;
    s = tval(k);
    if (fr != 0) s += ((tval(k + 1) - tval(k)) * fr + 64) / 128;
    return (q >= 2) ? -s : s;
  endfunction

  function automatic int ideal_val(logic f, logic [15:0] xv);
    real a, v;
    a = 2.0 * PI * real'(xv) / 65536.0;
    v = 16384.0 * (f ? $cos(a) : $sin(a));
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  task automatic issue(input logic f, input logic [15:0] xv, input int ex, input int tol,
                       input bit ideal, input bit sym);
    exp_t e;
    @(posedge clk);
    #1;
    func = f;
    x    = xv;
    e.due = cyc + LATENCY;
    e.f = f; e.xv = xv; e.exp = ex; e.tol = tol; e.ideal = ideal; e.sym = sym;
    sb.push_back(e);
  endtask

  task automatic issue_model(input logic f, input logic [15:0] xv, input bit sym);
    issue(f, xv, model(f, xv), 0, 1'b1, sym);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check("missed_sample", 0, 1, 0);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check(e.f ? "cos_value" : "sin_value", int'($signed(sineValue)), e.exp, e.tol);
        if (e.ideal)
          check("accuracy", int'($signed(sineValue)), ideal_val(e.f, e.xv), 2);
        if (e.sym) got_sin[int'(e.xv)] = sineValue;
      end
    end
  end

  logic [15:0] dir_x   [12] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                16'h3FFE, 16'h406E, 16'h08C0, 16'h88C0};
  logic        dir_f   [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int          dir_exp [12] = '{0, 16384, 0, -16384, 16384, 0, -16384, 0,
                                16384, 16383, 3492, -3492};
  int          dir_tol [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2};

  initial begin
    logic [15:0] rx;
    int          waited;

    // Held in reset with inputs moving: output must stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      x    = 16'($urandom);
      func = 1'($urandom);
      @(negedge clk);
      check("reset_hold", int'(sineValue), 0, 0);
    end
    @(posedge clk);
    #1;
    x     = 16'h0000;
    func  = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(dir_f[i], dir_x[i], dir_exp[i], dir_tol[i], 1'b0, 1'b0);
      if (i < 2) begin
        @(negedge clk);
        check("latency_hold", int'(sineValue), 0, 0);
      end
    end

    // Back-to-back with func toggling every cycle.
    for (int i = 0; i < 2000; i++) issue_model(1'(i), 16'($urandom), 1'b0);

    // Odd-symmetry pairs.
    for (int i = 0; i < 300; i++) begin
      rx = 16'($urandom_range(0, 32767));
      issue_model(1'b0, rx, 1'b1);
      issue_model(1'b0, rx + 16'h8000, 1'b1);
    end

    // Strided sweep of both functions, including segment boundaries.
    for (int i = 0; i < 65536; i += 97) begin
      issue_model(1'b0, 16'(i), 1'b0);
      issue_model(1'b1, 16'(i), 1'b0);
    end
    for (int i = 0; i < 65536; i += 128) issue_model(1'b1, 16'(i), 1'b0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0, 0);

    // Asynchronous reset in mid-stream clears the output without waiting for a clock.
    for (int i = 0; i < 5; i++) issue_model(1'b1, 16'($urandom), 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("async_clear", int'(sineValue), 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      x = 16'($urandom);
      @(negedge clk);
      check("reset_hold", int'(sineValue), 0, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) issue_model(1'(i), 16'($urandom), 1'b0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0, 0);

    foreach (got_sin[k]) begin
      if (k < 32768 && got_sin.exists(k + 32768))
        check("odd_symmetry", int'($signed(got_sin[k + 32768])), -int'($signed(got_sin[k])), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
